// File: rtl/sdram_init_checker_pkg.sv
// Shared definitions for the SDRAM power-up sequence checker.
// Holds the SDRAM command encodings {CS_N,RAS_N,CAS_N,WE_N}, the default
// address width, the error-cause codes and a command classifier used by
// the checker. No ports; imported by the interface and the modules.
package sdram_init_checker_pkg;

    localparam int ASIZE_DEFAULT = 13;
    localparam int ERR_W         = 3;
    localparam int A10           = 10;   // auto-precharge / "precharge all" bit

    localparam logic [3:0] CMD_LMR       = 4'b0000;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_BST       = 4'b0110;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    typedef enum logic [2:0] {
        KIND_IDLE,
        KIND_PRE,
        KIND_AREF,
        KIND_LMR,
        KIND_OTHER
    } cmd_kind_t;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 3'd0,
        ERR_POWERUP  = 3'd1,   // command before the power-up wait elapsed
        ERR_SEQUENCE = 3'd2,   // wrong command for the current step
        ERR_TRP      = 3'd3,
        ERR_TRFC     = 3'd4,
        ERR_REFRESH  = 3'd5,   // LMR too early or stray command while refreshing
        ERR_TMRD     = 3'd6
    } err_code_t;

    // Deselect (CS_N high) and NOP are both idle bus cycles.
    function automatic cmd_kind_t decode_cmd(input logic [3:0] cmd);
        cmd_kind_t kind;
        if (cmd[3] || cmd == CMD_NOP) begin
            kind = KIND_IDLE;
        end else begin
            case (cmd)
                CMD_PRECHARGE: kind = KIND_PRE;
                CMD_AREF:      kind = KIND_AREF;
                CMD_LMR:       kind = KIND_LMR;
                default:       kind = KIND_OTHER;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/sdram_init_checker_if.sv
// Bus bundle between the SDRAM command source and the init checker.
// Command/Saddr : command code and address driven by the controller.
// Init_ok/Init_err/Err_code/Mode_reg/Refresh_cnt : checker status.
// master = command source, slave = checker.
interface sdram_init_checker_if #(
    parameter int ASIZE = 13
);
    import sdram_init_checker_pkg::*;

    logic [3:0]       Command;
    logic [ASIZE-1:0] Saddr;
    logic             Init_ok;
    logic             Init_err;
    logic [ERR_W-1:0] Err_code;
    logic [ASIZE-1:0] Mode_reg;
    logic [3:0]       Refresh_cnt;

    modport master (
        output Command, Saddr,
        input  Init_ok, Init_err, Err_code, Mode_reg, Refresh_cnt
    );

    modport slave (
        input  Command, Saddr,
        output Init_ok, Init_err, Err_code, Mode_reg, Refresh_cnt
    );

endinterface

// File: rtl/sdram_gap_timer.sv
// Cycles-since-last-command counter for the init checker.
// clk, rst   : clock, asynchronous active-high reset
// cmd_valid  : a non-idle command is on the bus this cycle
// limit      : minimum gap required by the current step
// ge         : gap >= limit, i.e. a command now is timing-legal
// The count becomes 1 in the cycle after a command, then increments and
// saturates at 255.
module sdram_gap_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] limit,
    output logic       ge
);

    logic [7:0] gap_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_reg <= 8'd0;
        end else if (cmd_valid) begin
            gap_reg <= 8'd1;
        end else if (gap_reg != 8'hFF) begin
            gap_reg <= gap_reg + 8'd1;
        end
    end

    assign ge = (gap_reg >= limit);

endmodule

// File: rtl/sdram_init_checker.sv
// SDRAM power-up protocol watchdog. Follows the command bus through
// power-up wait -> PRECHARGE ALL -> N_REF x AUTO REFRESH -> LOAD MODE,
// checking every inter-command gap, and reports completion or the first
// violation (sticky until Rst).
// Clk, Rst : clock, asynchronous active-high reset
// bus      : slave side of sdram_init_checker_if (Command/Saddr in,
//            Init_ok/Init_err/Err_code/Mode_reg/Refresh_cnt out)
module sdram_init_checker
    import sdram_init_checker_pkg::*;
#(
    parameter int ASIZE     = ASIZE_DEFAULT,
    parameter int T_POWERUP = 20000,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int N_REF     = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    sdram_init_checker_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_PWR, ST_PRE, ST_REF, ST_MRD, ST_DONE, ST_ERR
    } state_t;

    localparam int         PW        = (T_POWERUP > 0) ? $clog2(T_POWERUP + 1) : 1;
    localparam logic [PW-1:0] PWR_MAX = PW'(T_POWERUP);
    localparam logic [7:0] LIM_RP    = 8'(T_RP);
    localparam logic [7:0] LIM_RFC   = 8'(T_RFC);
    localparam logic [7:0] LIM_MRD   = 8'(T_MRD);
    localparam logic [4:0] NREF_MIN  = 5'(N_REF);

    state_t           state_reg, state_next;
    err_code_t        err_code_reg, err_code_next;
    logic [ASIZE-1:0] mode_reg_reg, mode_reg_next;
    logic [3:0]       refresh_cnt_reg, refresh_cnt_next;
    logic [PW-1:0]    pwr_cnt_reg;
    logic             init_ok_reg, init_err_reg;

    cmd_kind_t        kind;
    logic             cmd_valid;
    logic             gap_ok;
    logic [7:0]       gap_limit;
    logic             pwr_done;

    assign kind      = decode_cmd(bus.Command);
    assign cmd_valid = (kind != KIND_IDLE);
    assign pwr_done  = (pwr_cnt_reg == PWR_MAX);

    // Each step is timed against the command that opened it.
    always_comb begin
        gap_limit = 8'd0;
        case (state_reg)
            ST_PRE:  gap_limit = LIM_RP;
            ST_REF:  gap_limit = LIM_RFC;
            ST_MRD:  gap_limit = LIM_MRD;
            default: gap_limit = 8'd0;
        endcase
    end

    sdram_gap_timer u_gap (
        .clk       (Clk),
        .rst       (Rst),
        .cmd_valid (cmd_valid),
        .limit     (gap_limit),
        .ge        (gap_ok)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pwr_cnt_reg <= '0;
        end else if (!pwr_done) begin
            pwr_cnt_reg <= pwr_cnt_reg + PW'(1);
        end
    end

    // Within each step the timing test comes first, so a command that is
    // both early and illegal reports the timing cause.
    always_comb begin
        state_next       = state_reg;
        err_code_next    = err_code_reg;
        mode_reg_next    = mode_reg_reg;
        refresh_cnt_next = refresh_cnt_reg;
        case (state_reg)
            ST_PWR: begin
                if (cmd_valid) begin
                    if (!pwr_done) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_POWERUP;
                    end else if (kind == KIND_PRE && bus.Saddr[A10]) begin
                        state_next = ST_PRE;
                    end else begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_SEQUENCE;
                    end
                end
            end
            ST_PRE: begin
                if (cmd_valid) begin
                    if (!gap_ok) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TRP;
                    end else if (kind == KIND_AREF) begin
                        state_next       = ST_REF;
                        refresh_cnt_next = 4'd1;
                    end else begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_SEQUENCE;
                    end
                end
            end
            ST_REF: begin
                if (cmd_valid) begin
                    if (!gap_ok) begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_TRFC;
                    end else if (kind == KIND_AREF) begin
                        refresh_cnt_next = (refresh_cnt_reg == 4'hF) ? 4'hF
                                                                      : refresh_cnt_reg + 4'd1;
                    end else if (kind == KIND_LMR && {1'b0, refresh_cnt_reg} >= NREF_MIN) begin
                        state_next    = ST_MRD;
                        mode_reg_next = bus.Saddr;
                    end else begin
                        state_next    = ST_ERR;
                        err_code_next = ERR_REFRESH;
                    end
                end
            end
            ST_MRD: begin
                // Once T_MRD has elapsed the sequence is complete whatever
                // is on the bus; before that any command is a violation.
                if (gap_ok) begin
                    state_next = ST_DONE;
                end else if (cmd_valid) begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_TMRD;
                end
            end
            default: begin
                state_next = state_reg;   // DONE and ERR hold until Rst
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg       <= ST_PWR;
            err_code_reg    <= ERR_NONE;
            mode_reg_reg    <= '0;
            refresh_cnt_reg <= 4'd0;
            init_ok_reg     <= 1'b0;
            init_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            err_code_reg    <= err_code_next;
            mode_reg_reg    <= mode_reg_next;
            refresh_cnt_reg <= refresh_cnt_next;
            init_ok_reg     <= (state_next == ST_DONE);
            init_err_reg    <= (state_next == ST_ERR);
        end
    end

    assign bus.Init_ok     = init_ok_reg;
    assign bus.Init_err    = init_err_reg;
    assign bus.Err_code    = err_code_reg;
    assign bus.Mode_reg    = mode_reg_reg;
    assign bus.Refresh_cnt = refresh_cnt_reg;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Randomized bench for sdram_init_checker. A reference model built from
// the protocol rules (edge index since reset release, index of the last
// command, refresh tally) predicts every output after every clock edge.
module tb_sdram_init_checker;
    import sdram_init_checker_pkg::*;

    localparam int ASIZE = 13;
    localparam int TPU   = 300;
    localparam int TRP   = 2;
    localparam int TRFC  = 7;
    localparam int TMRD  = 2;
    localparam int NREF  = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    sdram_init_checker_if #(.ASIZE(ASIZE)) bus ();

    sdram_init_checker #(
        .ASIZE(ASIZE), .T_POWERUP(TPU), .T_RP(TRP),
        .T_RFC(TRFC), .T_MRD(TMRD), .N_REF(NREF)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_n, m_last, m_lmr, m_naref, m_err;
    bit               m_pre, m_lmr_seen, m_done;
    logic [ASIZE-1:0] m_mode;

    function automatic void model_reset();
        m_n = 0; m_last = 0; m_lmr = 0; m_naref = 0; m_err = 0;
        m_pre = 0; m_lmr_seen = 0; m_done = 0; m_mode = '0;
    endfunction

    function automatic void model_step(input logic [3:0] cmd, input logic [ASIZE-1:0] addr);
        bit idle;
        int gap;
        m_n++;
        idle = cmd[3] || (cmd == 4'b0111);
        gap  = m_n - m_last;
        if (gap > 255) gap = 255;
        if (m_done || m_err != 0) begin
            // finished or failed: nothing more is judged
        end else if (m_lmr_seen) begin
            if (m_n - m_lmr >= TMRD)  m_done = 1;
            else if (!idle)           m_err = 6;
        end else if (!idle) begin
            if (!m_pre) begin
                if (m_n - 1 < TPU)                       m_err = 1;
                else if (cmd == 4'b0010 && addr[10])     m_pre = 1;
                else                                     m_err = 2;
            end else if (m_naref == 0) begin
                if (gap < TRP)                           m_err = 3;
                else if (cmd == 4'b0001)                 m_naref = 1;
                else                                     m_err = 2;
            end else begin
                if (gap < TRFC)                          m_err = 4;
                else if (cmd == 4'b0001)                 m_naref++;
                else if (cmd == 4'b0000 && m_naref >= NREF) begin
                    m_lmr_seen = 1; m_lmr = m_n; m_mode = addr;
                end else                                 m_err = 5;
            end
        end
        if (!idle) m_last = m_n;
    endfunction

    task automatic compare_all(input string where);
        int ref_exp;
        ref_exp = (m_naref > 15) ? 15 : m_naref;
        check_val({where, ".init_ok"},  32'(bus.Init_ok),     32'(m_done));
        check_val({where, ".init_err"}, 32'(bus.Init_err),    32'(m_err != 0));
        check_val({where, ".err_code"}, 32'(bus.Err_code),    32'(m_err));
        check_val({where, ".mode_reg"}, 32'(bus.Mode_reg),    32'(m_mode));
        check_val({where, ".ref_cnt"},  32'(bus.Refresh_cnt), 32'(ref_exp));
    endtask

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    function automatic logic [3:0] idle_cmd();
        logic [2:0] r;
        r = 3'($urandom);
        return ($urandom_range(0, 1) == 0) ? 4'b0111 : {1'b1, r};
    endfunction

    task automatic cyc(input logic [3:0] cmd, input logic [ASIZE-1:0] addr);
        bus.Command = cmd;
        bus.Saddr   = addr;
        @(posedge Clk);
        model_step(cmd, addr);
        #1;
        compare_all("cyc");
        if (!(cmd[3] || cmd == 4'b0111))
            $display("t=%0t cmd=%b addr=%h ok=%b err=%b code=%0d ref=%0d mode=%h",
                     $time, cmd, addr, bus.Init_ok, bus.Init_err, bus.Err_code,
                     bus.Refresh_cnt, bus.Mode_reg);
        @(negedge Clk);
    endtask

    task automatic idles(input int k);
        for (int i = 0; i < k; i++) cyc(idle_cmd(), ASIZE'($urandom));
    endtask

    // Command lands g cycles after the previous one.
    task automatic issue(input int g, input logic [3:0] cmd, input logic [ASIZE-1:0] addr);
        idles(g - 1);
        cyc(cmd, addr);
    endtask

    task automatic do_reset(input int hold);
        bus.Command = 4'b0111;
        Rst = 1'b1;
        model_reset();
        #1;
        compare_all("reset");
        repeat (hold) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // f: 0 legal, 1 early command, 2 PRE without A10, 3 tRP, 4 tRFC,
    //    5 too few refreshes, 6 tMRD, 7 stray READ while refreshing,
    //    8 reset mid-refresh then a legal run.
    task automatic scenario(input int f, input logic [ASIZE-1:0] lmr_addr);
        int passes;
        int nref;
        int fault;
        logic [ASIZE-1:0] pa;
        passes = (f == 8) ? 2 : 1;
        for (int p = 0; p < passes; p++) begin
            fault = (p == 0) ? f : 0;
            if (p == 1) do_reset(2);
            if (fault == 1) begin
                idles($urandom_range(0, TPU - 1));
                cyc(CMD_PRECHARGE, ASIZE'(1 << 10));
            end else begin
                idles(TPU + $urandom_range(0, 4));
                pa = ASIZE'($urandom);
                pa[10] = (fault != 2);
                cyc(CMD_PRECHARGE, pa);
                nref = (fault == 5) ? NREF - 1 : NREF + $urandom_range(0, 9);
                for (int i = 0; i < nref; i++) begin
                    if (fault == 8 && i == 4) break;
                    if (i == 0)
                        issue((fault == 3) ? 1 : TRP + $urandom_range(0, 3),
                              CMD_AREF, ASIZE'($urandom));
                    else
                        issue((fault == 4 && i == 1) ? $urandom_range(1, TRFC - 1)
                                                     : TRFC + $urandom_range(0, 3),
                              CMD_AREF, ASIZE'($urandom));
                end
                if (fault != 8) begin
                    if (fault == 7) issue(TRFC, CMD_READ, ASIZE'($urandom));
                    issue(TRFC + $urandom_range(0, 2), CMD_LMR, lmr_addr);
                    if (fault == 6) cyc(CMD_ACTIVE, ASIZE'($urandom));
                    else            idles(TMRD + $urandom_range(0, 3));
                end
            end
        end
        // later traffic: must leave DONE/ERR untouched
        for (int i = 0; i < 15; i++) begin
            if ($urandom_range(0, 1) == 0) cyc(idle_cmd(), ASIZE'($urandom));
            else cyc(4'($urandom), ASIZE'($urandom));
        end
    endtask

    initial begin
        bus.Command = 4'b0111;
        bus.Saddr   = '0;
        model_reset();
        do_reset(20);                       // release at 200 ns
        scenario(0, ASIZE'(13'h032));
        for (int f = 1; f <= 8; f++) begin
            do_reset(2);
            scenario(f, ASIZE'($urandom));
        end
        for (int k = 0; k < 10; k++) begin
            do_reset($urandom_range(1, 3));
            scenario($urandom_range(0, 8), ASIZE'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
